// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, command-word layout and request packing for uart_cmd_ctrl
package uart_pkg;
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ISSUE   = 2'd1;
   localparam logic [1:0] ST_WAIT_RD = 2'd2;
   localparam logic [1:0] ST_RESP    = 2'd3;
   localparam int CMD_RW_BIT   = 15;
   localparam int CMD_ADDR_MSB = 14;
   localparam int CMD_ADDR_LSB = 8;
   localparam int REQ_W        = 16;
   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      ISSUE   = ST_ISSUE,
      WAIT_RD = ST_WAIT_RD,
      RESP    = ST_RESP
   } state_t;
   // Requests are stored already formatted as uart command words; reads carry a zero data field.
   function automatic logic [REQ_W-1:0] make_cmd(input logic rw, input logic [6:0] addr, input logic [7:0] wdata);
      logic [REQ_W-1:0] c;
      c = '0;
      c[CMD_RW_BIT] = rw;
      c[CMD_ADDR_MSB:CMD_ADDR_LSB] = addr;
      c[CMD_ADDR_LSB-1:0] = rw ? 8'h00 : wdata;
      return c;
   endfunction
endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// uart_cmd_ctrl_if: host request/response, uart command and read-return signals of uart_cmd_ctrl
//   slave  : the controller side (takes requests, drives commands and responses)
//   master : the environment side (host + uart)
interface uart_cmd_ctrl_if;
   logic        req_vld;
   logic        req_rdy;
   logic        req_rw;
   logic [6:0]  req_addr;
   logic [7:0]  req_wdata;
   logic [15:0] cmd_in;
   logic        cmd_vld;
   logic        cmd_rdy;
   logic        read_rdy;
   logic [7:0]  read_data;
   logic        rsp_vld;
   logic        rsp_rdy;
   logic [7:0]  rsp_data;
   logic        rsp_err;
   logic [7:0]  drop_cnt;
   modport slave (
      input  req_vld, req_rw, req_addr, req_wdata, cmd_rdy, read_rdy, read_data, rsp_rdy,
      output req_rdy, cmd_in, cmd_vld, rsp_vld, rsp_data, rsp_err, drop_cnt
   );
   modport master (
      output req_vld, req_rw, req_addr, req_wdata, cmd_rdy, read_rdy, read_data, rsp_rdy,
      input  req_rdy, cmd_in, cmd_vld, rsp_vld, rsp_data, rsp_err, drop_cnt
   );
endinterface

// File: rtl/uart_req_fifo.sv
// uart_req_fifo: synchronous request FIFO
//   clk, rst        : clock, sync active-high reset (flushes pointers and occupancy)
//   push, din       : write when push && !full
//   pop, dout       : dout shows the head; pop removes it when !empty
//   full, empty     : derived from the registered occupancy counter
module uart_req_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   cnt;
   logic          do_push, do_pop;
   assign full    = cnt == (AW+1)'(DEPTH);
   assign empty   = cnt == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
         rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
         cnt    <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: buffers host register requests and issues them to the uart one at a time
//   clk, rst : clock, sync active-high reset
//   bus      : uart_cmd_ctrl_if.slave
//              req_*  host request (vld/rdy), cmd_* uart command (vld/rdy),
//              read_* uart read return, rsp_* in-order host response, drop_cnt stray read returns
module uart_cmd_ctrl
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = 20000,
   parameter int TO_W        = 16
) (
   input logic            clk,
   input logic            rst,
   uart_cmd_ctrl_if.slave bus
);
   state_t           state, state_n;
   logic [REQ_W-1:0] hold, hold_n, cmd_in, cmd_in_n, fifo_dout;
   logic             cmd_vld, cmd_vld_n, rsp_err, rsp_err_n;
   logic [7:0]       rsp_data, rsp_data_n, drop_cnt, drop_n;
   logic [TO_W-1:0]  cnt, cnt_n;
   logic             fifo_full, fifo_empty, push, pop;
   assign bus.req_rdy  = !fifo_full;
   assign push         = bus.req_vld && !fifo_full;
   assign bus.cmd_in   = cmd_in;
   assign bus.cmd_vld  = cmd_vld;
   assign bus.rsp_vld  = state == RESP;
   assign bus.rsp_data = rsp_data;
   assign bus.rsp_err  = rsp_err;
   assign bus.drop_cnt = drop_cnt;
   uart_req_fifo #(.DEPTH(FIFO_DEPTH), .W(REQ_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (make_cmd(bus.req_rw, bus.req_addr, bus.req_wdata)),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );
   always_comb begin
      state_n    = state;
      hold_n     = hold;
      cmd_in_n   = cmd_in;
      cmd_vld_n  = cmd_vld;
      rsp_data_n = rsp_data;
      rsp_err_n  = rsp_err;
      cnt_n      = cnt;
      pop        = 1'b0;
      drop_n     = (bus.read_rdy && state != WAIT_RD && drop_cnt != 8'hFF) ? drop_cnt + 8'd1 : drop_cnt;
      case (state)
         IDLE: if (!fifo_empty) begin
            pop     = 1'b1;
            hold_n  = fifo_dout;
            state_n = ISSUE;
         end
         // First ISSUE cycle registers the command; the word then stays put until accepted.
         ISSUE: if (!cmd_vld) begin
            cmd_vld_n = 1'b1;
            cmd_in_n  = hold;
         end else if (bus.cmd_rdy) begin
            cmd_vld_n  = 1'b0;
            cnt_n      = '0;
            rsp_data_n = 8'h00;
            rsp_err_n  = 1'b0;
            state_n    = hold[CMD_RW_BIT] ? WAIT_RD : RESP;
         end
         // A return landing on the timeout cycle still counts as a good read.
         WAIT_RD: begin
            cnt_n = cnt + TO_W'(1);
            if (bus.read_rdy) begin
               rsp_data_n = bus.read_data;
               rsp_err_n  = 1'b0;
               state_n    = RESP;
            end else if (cnt == TO_W'(TIMEOUT_CYC - 1)) begin
               rsp_data_n = 8'h00;
               rsp_err_n  = 1'b1;
               state_n    = RESP;
            end
         end
         RESP: if (bus.rsp_rdy) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         hold     <= '0;
         cmd_in   <= '0;
         cmd_vld  <= 1'b0;
         rsp_data <= 8'h00;
         rsp_err  <= 1'b0;
         cnt      <= '0;
         drop_cnt <= 8'h00;
      end else begin
         state    <= state_n;
         hold     <= hold_n;
         cmd_in   <= cmd_in_n;
         cmd_vld  <= cmd_vld_n;
         rsp_data <= rsp_data_n;
         rsp_err  <= rsp_err_n;
         cnt      <= cnt_n;
         drop_cnt <= drop_n;
      end
   end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed self-checking bench for uart_cmd_ctrl
module tb_uart_cmd_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_cmp = 0;
   int n_err = 0;
   uart_cmd_ctrl_if bus ();
   uart_cmd_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CYC(50), .TO_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic set_req(input logic vld, input logic rw, input logic [6:0] addr, input logic [7:0] wd);
      bus.req_vld   = vld;
      bus.req_rw    = rw;
      bus.req_addr  = addr;
      bus.req_wdata = wd;
   endtask
   task automatic wait_cmd(input string tag);
      int w;
      w = 0;
      while (bus.cmd_vld !== 1'b1 && w < 20) begin
         tick();
         w++;
      end
      chk(tag, 16'(bus.cmd_vld), 16'h1);
   endtask
   initial begin
      logic any_rsp;
      logic any_cmd;
      set_req(0, 0, 7'h00, 8'h00);
      bus.cmd_rdy   = 1'b0;
      bus.read_rdy  = 1'b0;
      bus.read_data = 8'h00;
      bus.rsp_rdy   = 1'b0;
      tick();
      tick();
      chk("rst_cmd_vld", 16'(bus.cmd_vld), 16'h0);
      chk("rst_cmd_in", bus.cmd_in, 16'h0000);
      chk("rst_rsp_vld", 16'(bus.rsp_vld), 16'h0);
      chk("rst_rsp_data", 16'(bus.rsp_data), 16'h00);
      chk("rst_rsp_err", 16'(bus.rsp_err), 16'h0);
      chk("rst_drop", 16'(bus.drop_cnt), 16'h00);
      chk("rst_req_rdy", 16'(bus.req_rdy), 16'h1);
      rst = 1'b0;
      tick();
      // write path
      bus.cmd_rdy = 1'b1;
      set_req(1, 0, 7'h05, 8'h3C);
      tick();
      set_req(0, 0, 7'h00, 8'h00);
      chk("wr_vld_n0", 16'(bus.cmd_vld), 16'h0);
      tick();
      chk("wr_vld_n1", 16'(bus.cmd_vld), 16'h0);
      tick();
      chk("wr_vld_n2", 16'(bus.cmd_vld), 16'h1);
      chk("wr_cmd_in", bus.cmd_in, 16'h053C);
      tick();
      chk("wr_vld_n3", 16'(bus.cmd_vld), 16'h0);
      chk("wr_rsp_vld", 16'(bus.rsp_vld), 16'h1);
      chk("wr_rsp_data", 16'(bus.rsp_data), 16'h00);
      chk("wr_rsp_err", 16'(bus.rsp_err), 16'h0);
      tick();
      chk("wr_rsp_hold", 16'(bus.rsp_vld), 16'h1);
      bus.rsp_rdy = 1'b1;
      tick();
      bus.rsp_rdy = 1'b0;
      chk("wr_rsp_done", 16'(bus.rsp_vld), 16'h0);
      // read path with cmd back-pressure
      bus.cmd_rdy = 1'b0;
      set_req(1, 1, 7'h12, 8'hFF);
      tick();
      set_req(0, 0, 7'h00, 8'h00);
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("rd_vld_held", 16'(bus.cmd_vld), 16'h1);
         chk("rd_cmd_held", bus.cmd_in, 16'h9200);
         tick();
      end
      bus.cmd_rdy = 1'b1;
      tick();
      bus.cmd_rdy = 1'b0;
      chk("rd_vld_drop", 16'(bus.cmd_vld), 16'h0);
      tick();
      tick();
      chk("rd_no_rsp_yet", 16'(bus.rsp_vld), 16'h0);
      bus.read_rdy  = 1'b1;
      bus.read_data = 8'hA5;
      tick();
      bus.read_rdy = 1'b0;
      chk("rd_rsp_vld", 16'(bus.rsp_vld), 16'h1);
      chk("rd_rsp_data", 16'(bus.rsp_data), 16'h00A5);
      chk("rd_rsp_err", 16'(bus.rsp_err), 16'h0);
      bus.rsp_rdy = 1'b1;
      tick();
      bus.rsp_rdy = 1'b0;
      chk("rd_rsp_done", 16'(bus.rsp_vld), 16'h0);
      // timeout
      bus.cmd_rdy = 1'b1;
      set_req(1, 1, 7'h33, 8'h00);
      tick();
      set_req(0, 0, 7'h00, 8'h00);
      tick();
      tick();
      chk("to_cmd_in", bus.cmd_in, 16'hB300);
      tick();
      chk("to_xfer", 16'(bus.cmd_vld), 16'h0);
      for (int i = 1; i < 50; i++) tick();
      chk("to_not_early", 16'(bus.rsp_vld), 16'h0);
      tick();
      chk("to_rsp_vld", 16'(bus.rsp_vld), 16'h1);
      chk("to_rsp_err", 16'(bus.rsp_err), 16'h1);
      chk("to_rsp_data", 16'(bus.rsp_data), 16'h00);
      bus.rsp_rdy = 1'b1;
      tick();
      bus.rsp_rdy = 1'b0;
      // read return on the timeout cycle wins
      set_req(1, 1, 7'h34, 8'h00);
      tick();
      set_req(0, 0, 7'h00, 8'h00);
      tick();
      tick();
      tick();
      chk("tr_xfer", 16'(bus.cmd_vld), 16'h0);
      for (int i = 1; i < 50; i++) tick();
      bus.read_rdy  = 1'b1;
      bus.read_data = 8'h5A;
      tick();
      bus.read_rdy = 1'b0;
      chk("tr_rsp_vld", 16'(bus.rsp_vld), 16'h1);
      chk("tr_rsp_err", 16'(bus.rsp_err), 16'h0);
      chk("tr_rsp_data", 16'(bus.rsp_data), 16'h005A);
      chk("tr_no_drop", 16'(bus.drop_cnt), 16'h00);
      bus.rsp_rdy = 1'b1;
      tick();
      bus.rsp_rdy = 1'b0;
      // FIFO full and ordering
      bus.cmd_rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("ff_rdy_before", 16'(bus.req_rdy), 16'h1);
         set_req(1, 0, 7'(7'h10 + i), 8'(8'hA0 + i));
         tick();
      end
      set_req(0, 0, 7'h00, 8'h00);
      chk("ff_full", 16'(bus.req_rdy), 16'h0);
      bus.cmd_rdy = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wait_cmd("ff_wait_cmd");
         chk("ff_order", bus.cmd_in, {1'b0, 7'(7'h10 + k), 8'(8'hA0 + k)});
         tick();
         chk("ff_rsp_vld", 16'(bus.rsp_vld), 16'h1);
         if (k == 0)
            for (int j = 0; j < 3; j++) begin
               tick();
               chk("ff_rsp_hold", 16'(bus.rsp_vld), 16'h1);
            end
         bus.rsp_rdy = 1'b1;
         tick();
         bus.rsp_rdy = 1'b0;
         chk("ff_rsp_done", 16'(bus.rsp_vld), 16'h0);
      end
      chk("ff_drained_rdy", 16'(bus.req_rdy), 16'h1);
      // stray read returns saturate drop_cnt
      any_rsp = 1'b0;
      for (int i = 0; i < 300; i++) begin
         bus.read_rdy = 1'b1;
         tick();
         bus.read_rdy = 1'b0;
         any_rsp |= bus.rsp_vld;
         tick();
         if (i == 99) chk("drop_100", 16'(bus.drop_cnt), 16'h0064);
         if (i == 253) chk("drop_254", 16'(bus.drop_cnt), 16'h00FE);
      end
      chk("drop_sat", 16'(bus.drop_cnt), 16'h00FF);
      chk("drop_no_rsp", 16'(any_rsp), 16'h0);
      // reset mid-read with two requests queued
      bus.cmd_rdy = 1'b1;
      set_req(1, 1, 7'h01, 8'h00);
      tick();
      set_req(1, 0, 7'h02, 8'h11);
      tick();
      set_req(1, 0, 7'h03, 8'h22);
      tick();
      set_req(0, 0, 7'h00, 8'h00);
      chk("mr_cmd_vld", 16'(bus.cmd_vld), 16'h1);
      tick();
      chk("mr_xfer", 16'(bus.cmd_vld), 16'h0);
      bus.cmd_rdy = 1'b0;
      tick();
      tick();
      chk("mr_drop_pre", 16'(bus.drop_cnt), 16'h00FF);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_cmd_vld0", 16'(bus.cmd_vld), 16'h0);
      chk("mr_rsp_vld0", 16'(bus.rsp_vld), 16'h0);
      chk("mr_req_rdy", 16'(bus.req_rdy), 16'h1);
      chk("mr_drop0", 16'(bus.drop_cnt), 16'h00);
      bus.cmd_rdy = 1'b1;
      bus.rsp_rdy = 1'b1;
      any_rsp = 1'b0;
      any_cmd = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         any_rsp |= bus.rsp_vld;
         any_cmd |= bus.cmd_vld;
      end
      chk("mr_no_rsp", 16'(any_rsp), 16'h0);
      chk("mr_no_cmd", 16'(any_cmd), 16'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
